// File: rtl/skein_instr_pkg.sv
// Shared definitions for the instruction-bus sequencers: field layout,
// opcode and global-command constants, FSM state type and a packing helper.
package skein_instr_pkg;

    // Default field widths of the core instruction word
    localparam int ADDR_W_DEF  = 8;
    localparam int OPC_W_DEF   = 4;
    localparam int GCMD_W_DEF  = 3;
    localparam int INSTR_W_DEF = 1 + 1 + ADDR_W_DEF + 2 + 1 + 1 + OPC_W_DEF + GCMD_W_DEF;

    // Bit offsets (LSB of each field) for the default layout
    localparam int GCMD_LSB = 0;
    localparam int OPC_LSB  = GCMD_LSB + GCMD_W_DEF;
    localparam int OE_BIT   = OPC_LSB + OPC_W_DEF;
    localparam int OS_BIT   = OE_BIT + 1;
    localparam int IS_LSB   = OS_BIT + 1;
    localparam int ADDR_LSB = IS_LSB + 2;
    localparam int RW_BIT   = ADDR_LSB + ADDR_W_DEF;
    localparam int SCS_BIT  = RW_BIT + 1;

    // ALU opcodes
    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ADD   = 4'h1;
    localparam logic [3:0] OPC_SUB   = 4'h2;
    localparam logic [3:0] OPC_COUNT = 4'h3;

    // Global commands
    localparam logic [2:0] GCMD_NONE = 3'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Packs a default-width instruction with all non-ALU/RAM controls inactive
    function automatic logic [INSTR_W_DEF-1:0] pack_instr(
        input logic                  ram_write,
        input logic [ADDR_W_DEF-1:0] address,
        input logic [OPC_W_DEF-1:0]  alu_opcode
    );
        return {1'b0, ram_write, address, 2'b00, 1'b0, 1'b0, alu_opcode, GCMD_NONE};
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Pure combinational packer: individual instruction fields in, packed
// instruction word out. Shared by all sequencers that drive the bus.
module instr_field_packer #(
    parameter int ADDR_W  = 8,
    parameter int OPC_W   = 4,
    parameter int GCMD_W  = 3,
    parameter int INSTR_W = 21
) (
    input  logic               save_core_sel,
    input  logic               ram_write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [1:0]         input_select,
    input  logic               output_select,
    input  logic               output_enable,
    input  logic [OPC_W-1:0]   alu_opcode,
    input  logic [GCMD_W-1:0]  global_command,
    output logic [INSTR_W-1:0] instr
);

    generate
        if (INSTR_W != 1 + 1 + ADDR_W + 2 + 1 + 1 + OPC_W + GCMD_W) begin : g_width_check
            $error("instr_field_packer: INSTR_W does not match the sum of field widths");
        end
    endgenerate

    // MSB-to-LSB field concatenation
    always_comb begin
        instr = {save_core_sel, ram_write, address, input_select,
                 output_select, output_enable, alu_opcode, global_command};
    end

endmodule

// File: rtl/loop_instruction_sequencer.sv
// Drives one packed core instruction onto the shared tri-state bus for a
// programmable number of cycles, stepping the RAM address each cycle.
// Cycle 0 is driven combinationally from the inputs; later cycles come from
// the fields latched at start. Abort, busy and done status are provided.
module loop_instruction_sequencer
    import skein_instr_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int ADDR_W  = 8,
    parameter int OPC_W   = 4,
    parameter int GCMD_W  = 3,
    parameter int INSTR_W = 21
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [CNT_W-1:0]   count_i,
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [ADDR_W-1:0]  addr_base_i,
    input  logic [ADDR_W-1:0]  addr_step_i,
    input  logic               ram_we_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o
);

    // One extra bit so that count_i==0 can stand for 2**CNT_W
    localparam int REM_W = CNT_W + 1;

    seq_state_e         state;
    logic [REM_W-1:0]   remaining;
    logic               aborted_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  step_q;
    logic [OPC_W-1:0]   opc_q;
    logic               we_q;

    logic [REM_W-1:0]   run_len;
    logic               start_go;
    logic               in_run;
    logic [ADDR_W-1:0]  cur_addr;
    logic [OPC_W-1:0]   cur_opc;
    logic               cur_we;
    logic [INSTR_W-1:0] packed_instr;

    // Decode run length, cycle qualifiers and the field source for this cycle.
    // While rst_ni is low the bus is released and done is held off, so a
    // reset never shows a partial instruction or a completion.
    always_comb begin
        run_len  = (count_i == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count_i};
        start_go = rst_ni && (state == ST_IDLE) && start_i;
        in_run   = rst_ni && (state == ST_RUN);
        cur_addr = addr_q;
        cur_opc  = opc_q;
        cur_we   = we_q;
        if (state == ST_IDLE) begin
            cur_addr = addr_base_i;
            cur_opc  = opcode_i;
            cur_we   = ram_we_i;
        end
        done_o = (start_go && (run_len == REM_W'(1)))
              || (in_run && (remaining == REM_W'(1)) && !abort_i);
        busy_o    = (state == ST_RUN);
        aborted_o = aborted_q;
    end

    instr_field_packer #(
        .ADDR_W  (ADDR_W),
        .OPC_W   (OPC_W),
        .GCMD_W  (GCMD_W),
        .INSTR_W (INSTR_W)
    ) u_packer (
        .save_core_sel  (1'b0),
        .ram_write      (cur_we),
        .address        (cur_addr),
        .input_select   (2'b00),
        .output_select  (1'b0),
        .output_enable  (1'b0),
        .alu_opcode     (cur_opc),
        .global_command (GCMD_W'(0)),
        .instr          (packed_instr)
    );

    // The only tri-state driver: own the bus only on start and run cycles
    assign instruction_o = (start_go || in_run) ? packed_instr : {INSTR_W{1'bz}};

    // Control FSM: run counter and abort pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            remaining <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i && (run_len != REM_W'(1))) begin
                        remaining <= run_len - REM_W'(1);
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        remaining <= '0;
                        aborted_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (remaining == REM_W'(1)) begin
                        remaining <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        remaining <= remaining - REM_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Field latch and address accumulator; carry out of the adder is dropped
    always_ff @(posedge clk_i) begin
        if (start_go) begin
            addr_q <= addr_base_i + addr_step_i;
            step_q <= addr_step_i;
            opc_q  <= opcode_i;
            we_q   <= ram_we_i;
        end else if (state == ST_RUN) begin
            addr_q <= addr_q + step_q;
        end
    end

endmodule

// File: tb/tb_loop_instruction_sequencer.sv
// Scoreboard bench for loop_instruction_sequencer: the stimulus process pushes
// the expected outputs of every cycle it drives; a monitor pops and compares
// on the falling edge.
module tb_loop_instruction_sequencer;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic [5:0]  count_i;
    logic [3:0]  opcode_i;
    logic [7:0]  addr_base_i;
    logic [7:0]  addr_step_i;
    logic        ram_we_i;
    wire  [20:0] instruction_o;
    logic        busy_o;
    logic        done_o;
    logic        aborted_o;

    typedef struct {
        logic        z;
        logic [20:0] ins;
        logic        busy;
        logic        done;
        logic        ab;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    loop_instruction_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .count_i       (count_i),
        .opcode_i      (opcode_i),
        .addr_base_i   (addr_base_i),
        .addr_step_i   (addr_step_i),
        .ram_we_i      (ram_we_i),
        .instruction_o (instruction_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent field layout of the instruction word
    function automatic logic [20:0] pk(input logic we, input logic [7:0] a, input logic [3:0] o);
        return {1'b0, we, a, 2'b00, 1'b0, 1'b0, o, 3'b000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: one expected entry per driven cycle
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (e.z) ok = (instruction_o === 21'bz);
                else     ok = (instruction_o === e.ins);
                if (ok) n_pass++;
                else $display("FAIL %s bus: got %h expected %s%h", e.tag, instruction_o,
                              e.z ? "Z " : "", e.ins);
                chk({e.tag, " busy"},    {31'd0, busy_o},    {31'd0, e.busy});
                chk({e.tag, " done"},    {31'd0, done_o},    {31'd0, e.done});
                chk({e.tag, " aborted"}, {31'd0, aborted_o}, {31'd0, e.ab});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input logic z, input logic [20:0] ins, input logic b,
                              input logic d, input logic a, input string tag);
        exp_t e;
        e.z = z; e.ins = ins; e.busy = b; e.done = d; e.ab = a; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic set_run(input logic [5:0] c, input logic [3:0] o, input logic [7:0] b,
                           input logic [7:0] s, input logic we);
        count_i = c; opcode_i = o; addr_base_i = b; addr_step_i = s; ram_we_i = we;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b1; abort_i = 1'b0;
        set_run(6'd5, 4'h3, 8'h12, 8'h01, 1'b1);

        // 1. reset with start held high, then idle
        tick();
        expect_cyc(1, '0, 0, 0, 0, "rst0");
        tick();
        expect_cyc(1, '0, 0, 0, 0, "rst1");
        tick(); rst_ni = 1'b1; start_i = 1'b0;
        expect_cyc(1, '0, 0, 0, 0, "idle0");
        tick();
        expect_cyc(1, '0, 0, 0, 0, "idle1");

        // 2. count 0 means 64 cycles
        tick(); start_i = 1'b1; set_run(6'd0, 4'h3, 8'h00, 8'h00, 1'b0);
        expect_cyc(0, 21'h000018, 0, 0, 0, "n64 k0");
        for (int k = 1; k < 64; k++) begin
            tick(); start_i = 1'b0;
            expect_cyc(0, 21'h000018, 1, (k == 63), 0, $sformatf("n64 k%0d", k));
        end
        tick();
        expect_cyc(1, '0, 0, 0, 0, "n64 end");

        // 3. address wrap, inputs changed mid-run must not matter
        tick(); start_i = 1'b1; set_run(6'd5, 4'h3, 8'hFE, 8'h01, 1'b1);
        expect_cyc(0, pk(1, 8'hFE, 4'h3), 0, 0, 0, "wrap k0");
        tick(); start_i = 1'b0; set_run(6'd9, 4'h9, 8'h11, 8'h07, 1'b0);
        expect_cyc(0, pk(1, 8'hFF, 4'h3), 1, 0, 0, "wrap k1");
        tick(); expect_cyc(0, pk(1, 8'h00, 4'h3), 1, 0, 0, "wrap k2");
        tick(); expect_cyc(0, pk(1, 8'h01, 4'h3), 1, 0, 0, "wrap k3");
        tick(); expect_cyc(0, pk(1, 8'h02, 4'h3), 1, 1, 0, "wrap k4");
        tick(); expect_cyc(1, '0, 0, 0, 0, "wrap end");

        // 4. single-cycle run (abort in IDLE ignored), then back-to-back runs
        tick(); start_i = 1'b1; abort_i = 1'b1; set_run(6'd1, 4'h5, 8'h33, 8'h01, 1'b1);
        expect_cyc(0, pk(1, 8'h33, 4'h5), 0, 1, 0, "n1 k0");
        tick(); abort_i = 1'b0; set_run(6'd3, 4'hA, 8'h10, 8'h20, 1'b0);
        expect_cyc(0, pk(0, 8'h10, 4'hA), 0, 0, 0, "b2b k0");
        tick(); start_i = 1'b0;
        expect_cyc(0, pk(0, 8'h30, 4'hA), 1, 0, 0, "b2b k1");
        tick(); expect_cyc(0, pk(0, 8'h50, 4'hA), 1, 1, 0, "b2b k2");
        tick(); start_i = 1'b1; set_run(6'd2, 4'h1, 8'h40, 8'hFF, 1'b1);
        expect_cyc(0, pk(1, 8'h40, 4'h1), 0, 0, 0, "b2c k0");
        tick(); start_i = 1'b0;
        expect_cyc(0, pk(1, 8'h3F, 4'h1), 1, 1, 0, "b2c k1");
        tick(); expect_cyc(1, '0, 0, 0, 0, "b2c end");

        // 5a. abort mid-run
        tick(); start_i = 1'b1; set_run(6'd10, 4'h4, 8'h00, 8'h01, 1'b0);
        expect_cyc(0, pk(0, 8'h00, 4'h4), 0, 0, 0, "ab k0");
        tick(); start_i = 1'b0;
        expect_cyc(0, pk(0, 8'h01, 4'h4), 1, 0, 0, "ab k1");
        tick(); expect_cyc(0, pk(0, 8'h02, 4'h4), 1, 0, 0, "ab k2");
        tick(); abort_i = 1'b1;
        expect_cyc(0, pk(0, 8'h03, 4'h4), 1, 0, 0, "ab k3");
        tick(); abort_i = 1'b0;
        expect_cyc(1, '0, 0, 0, 1, "ab k4");
        tick(); expect_cyc(1, '0, 0, 0, 0, "ab k5");

        // 5b. abort on the last cycle suppresses done
        tick(); start_i = 1'b1; set_run(6'd3, 4'h2, 8'h05, 8'h02, 1'b1);
        expect_cyc(0, pk(1, 8'h05, 4'h2), 0, 0, 0, "abl k0");
        tick(); start_i = 1'b0;
        expect_cyc(0, pk(1, 8'h07, 4'h2), 1, 0, 0, "abl k1");
        tick(); abort_i = 1'b1;
        expect_cyc(0, pk(1, 8'h09, 4'h2), 1, 0, 0, "abl k2");
        tick(); abort_i = 1'b0;
        expect_cyc(1, '0, 0, 0, 1, "abl k3");
        tick(); expect_cyc(1, '0, 0, 0, 0, "abl k4");

        // 6. start held high through the run, reset on the would-be last cycle
        tick(); start_i = 1'b1; set_run(6'd4, 4'h2, 8'h80, 8'h01, 1'b0);
        expect_cyc(0, pk(0, 8'h80, 4'h2), 0, 0, 0, "hold k0");
        tick(); set_run(6'd2, 4'h7, 8'h00, 8'h10, 1'b1);
        expect_cyc(0, pk(0, 8'h81, 4'h2), 1, 0, 0, "hold k1");
        tick(); expect_cyc(0, pk(0, 8'h82, 4'h2), 1, 0, 0, "hold k2");
        tick(); rst_ni = 1'b0;
        expect_cyc(1, '0, 1, 0, 0, "hold k3 rst");
        tick(); rst_ni = 1'b1; start_i = 1'b0;
        expect_cyc(1, '0, 0, 0, 0, "post rst0");
        tick(); expect_cyc(1, '0, 0, 0, 0, "post rst1");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
